// File: rtl/seg7_scan_decoder_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Purpose : shared 7-segment constants for the clock display encoder and the
//           scan-side decoder. Patterns are active-low, bit 6 = g ... bit 0 = a.
// Contents: SEG7_PAT_0..SEG7_PAT_F pattern constants, blank/dash/A/P code
//           constants, decoder FSM state type, seg7_decode() helper returning
//           {known, code[3:0]}.
// Options : none (the decoder's SEG7_SCAN_DECODER_TIMEOUT_EN does not affect
//           this package).
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [6:0] SEG7_PAT_0 = 7'b1000000;
   localparam logic [6:0] SEG7_PAT_1 = 7'b1111001;
   localparam logic [6:0] SEG7_PAT_2 = 7'b0100100;
   localparam logic [6:0] SEG7_PAT_3 = 7'b0110000;
   localparam logic [6:0] SEG7_PAT_4 = 7'b0011001;
   localparam logic [6:0] SEG7_PAT_5 = 7'b0010010;
   localparam logic [6:0] SEG7_PAT_6 = 7'b0000010;
   localparam logic [6:0] SEG7_PAT_7 = 7'b1111000;
   localparam logic [6:0] SEG7_PAT_8 = 7'b0000000;
   localparam logic [6:0] SEG7_PAT_9 = 7'b0010000;
   localparam logic [6:0] SEG7_PAT_A = 7'b0001000;
   localparam logic [6:0] SEG7_PAT_B = 7'b0001100;  // shown as 'P'
   localparam logic [6:0] SEG7_PAT_C = 7'b0111001;
   localparam logic [6:0] SEG7_PAT_D = 7'b0001111;
   localparam logic [6:0] SEG7_PAT_E = 7'b0111111;  // shown as '-'
   localparam logic [6:0] SEG7_PAT_F = 7'b1111111;  // blank

   localparam logic [3:0] SEG7_CODE_BLANK = 4'hF;
   localparam logic [3:0] SEG7_CODE_DASH  = 4'hE;
   localparam logic [3:0] SEG7_CODE_A     = 4'hA;
   localparam logic [3:0] SEG7_CODE_P     = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } seg7_state_t;

   // Returns {known, code}; unknown patterns report code = blank.
   function automatic logic [4:0] seg7_decode(input logic [6:0] pat);
      logic [4:0] res;
      res = {1'b0, SEG7_CODE_BLANK};
      case (pat)
         SEG7_PAT_0: res = {1'b1, 4'h0};
         SEG7_PAT_1: res = {1'b1, 4'h1};
         SEG7_PAT_2: res = {1'b1, 4'h2};
         SEG7_PAT_3: res = {1'b1, 4'h3};
         SEG7_PAT_4: res = {1'b1, 4'h4};
         SEG7_PAT_5: res = {1'b1, 4'h5};
         SEG7_PAT_6: res = {1'b1, 4'h6};
         SEG7_PAT_7: res = {1'b1, 4'h7};
         SEG7_PAT_8: res = {1'b1, 4'h8};
         SEG7_PAT_9: res = {1'b1, 4'h9};
         SEG7_PAT_A: res = {1'b1, SEG7_CODE_A};
         SEG7_PAT_B: res = {1'b1, SEG7_CODE_P};
         SEG7_PAT_C: res = {1'b1, 4'hC};
         SEG7_PAT_D: res = {1'b1, 4'hD};
         SEG7_PAT_E: res = {1'b1, SEG7_CODE_DASH};
         SEG7_PAT_F: res = {1'b1, SEG7_CODE_BLANK};
         default:    res = {1'b0, SEG7_CODE_BLANK};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
// Purpose : display-bus / status bundle between the scan monitor and its user.
// Signals : seg_i (7, active-low segments), dig_sel_i (NUM_DIGITS, active-low
//           strobes), err_clr_i (error clear), digits_o (4*NUM_DIGITS codes),
//           valid_o (NUM_DIGITS), upd_o, upd_idx_o (3), err_o, err_idx_o (3).
// Modports: master = stimulus/consumer side, slave = seg7_scan_decoder.
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [6:0]              seg_i;
   logic [NUM_DIGITS-1:0]   dig_sel_i;
   logic                    err_clr_i;
   logic [4*NUM_DIGITS-1:0] digits_o;
   logic [NUM_DIGITS-1:0]   valid_o;
   logic                    upd_o;
   logic [2:0]              upd_idx_o;
   logic                    err_o;
   logic [2:0]              err_idx_o;

   modport master (
      output seg_i, dig_sel_i, err_clr_i,
      input  digits_o, valid_o, upd_o, upd_idx_o, err_o, err_idx_o
   );

   modport slave (
      input  seg_i, dig_sel_i, err_clr_i,
      output digits_o, valid_o, upd_o, upd_idx_o, err_o, err_idx_o
   );
endinterface

// File: rtl/seg7_scan_decoder_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Purpose : combinational 7-segment pattern to 4-bit code decoder.
// Ports   : i_pat (7, active-low pattern), o_known (pattern is in the table),
//           o_code (4, decoded code; blank when unknown).
// -----------------------------------------------------------------------------
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_pat,
   output logic       o_known,
   output logic [3:0] o_code
);
   logic [4:0] w_dec;

   always_comb begin
      w_dec   = seg7_decode(i_pat);
      o_known = w_dec[4];
      o_code  = w_dec[3:0];
   end
endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Purpose : monitors a multiplexed active-low 7-segment bus, filters each
//           strobe window for stability and recovers per-digit 4-bit codes.
// Ports   : clk, rst (synchronous, active-high); bus (seg7_scan_decoder_if
//           slave): seg_i, dig_sel_i, err_clr_i in; digits_o, valid_o, upd_o,
//           upd_idx_o, err_o, err_idx_o out.
// Options : `define SEG7_SCAN_DECODER_TIMEOUT_EN adds per-digit refresh
//           counters that drop valid/code after TIMEOUT_CYCLES without accept.
// -----------------------------------------------------------------------------
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   seg7_scan_decoder_if.slave    bus
);
`ifdef SEG7_SCAN_DECODER_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0]           r_tmo [NUM_DIGITS];
`endif

   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_sel;
   seg7_state_t             r_state;
   logic [7:0]              r_cnt;
   logic [2:0]              r_idx;
   logic [6:0]              r_pat;
   logic                    r_pend;
   logic [4*NUM_DIGITS-1:0] r_digits;
   logic [NUM_DIGITS-1:0]   r_valid;
   logic                    r_upd;
   logic [2:0]              r_upd_idx;
   logic                    r_err;
   logic [2:0]              r_err_idx;

   logic                    w_legal;
   logic [2:0]              w_idx;
   logic                    w_same;
   logic                    w_known;
   logic [3:0]              w_code;
   logic                    w_new_err;

   seg7_pattern_decode u_dec (
      .i_pat   (r_pat),
      .o_known (w_known),
      .o_code  (w_code)
   );

   // Strobe legality: exactly one low bit among the registered strobes.
   always_comb begin
      logic [3:0] nlow;
      nlow  = '0;
      w_idx = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (!r_sel[k]) begin
            nlow  = 4'(nlow + 4'd1);
            w_idx = 3'(k);
         end
      end
      w_legal   = (nlow == 4'd1);
      w_same    = (w_idx == r_idx) && (r_seg == r_pat);
      // A fresh error overrides a simultaneous clear.
      w_new_err = r_pend && !w_known && (!r_err || bus.err_clr_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg     <= '1;
         r_sel     <= '1;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_pat     <= '1;
         r_pend    <= 1'b0;
         r_digits  <= '1;
         r_valid   <= '0;
         r_upd     <= 1'b0;
         r_upd_idx <= '0;
         r_err     <= 1'b0;
         r_err_idx <= '0;
`ifdef SEG7_SCAN_DECODER_TIMEOUT_EN
         for (int unsigned k = 0; k < NUM_DIGITS; k++) r_tmo[k] <= '0;
`endif
      end else begin
         r_seg  <= bus.seg_i;
         r_sel  <= bus.dig_sel_i;
         r_upd  <= 1'b0;
         r_pend <= 1'b0;

         // Accept stage: runs one cycle after the stability count completes,
         // using the pattern/index latched when the window began.
         for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (r_pend && w_known && (r_idx == 3'(k))) begin
               r_digits[4*k +: 4] <= w_code;
               r_valid[k]         <= 1'b1;
               if (!r_valid[k] || (r_digits[4*k +: 4] != w_code)) begin
                  r_upd     <= 1'b1;
                  r_upd_idx <= r_idx;
               end
`ifdef SEG7_SCAN_DECODER_TIMEOUT_EN
               r_tmo[k] <= '0;
            end else if (r_valid[k]) begin
               if (r_tmo[k] == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_valid[k]         <= 1'b0;
                  r_digits[4*k +: 4] <= SEG7_CODE_BLANK;
                  r_tmo[k]           <= '0;
               end else begin
                  r_tmo[k] <= TW'(r_tmo[k] + 1'b1);
               end
`endif
            end
         end

         if (w_new_err) begin
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
         end else if (bus.err_clr_i) begin
            r_err     <= 1'b0;
            r_err_idx <= '0;
         end

         if (!w_legal) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_idx   <= w_idx;
                  r_pat   <= r_seg;
                  r_cnt   <= 8'd1;
                  r_state <= ST_SETTLE;
               end
               ST_SETTLE: begin
                  if (w_same) begin
                     if (r_cnt == 8'(STABLE_CYCLES - 1)) begin
                        r_cnt   <= 8'(STABLE_CYCLES);
                        r_state <= ST_HOLD;
                        r_pend  <= 1'b1;
                     end else begin
                        r_cnt <= 8'(r_cnt + 8'd1);
                     end
                  end else begin
                     r_idx <= w_idx;
                     r_pat <= r_seg;
                     r_cnt <= 8'd1;
                  end
               end
               ST_HOLD: begin
                  if (!w_same) begin
                     r_idx   <= w_idx;
                     r_pat   <= r_seg;
                     r_cnt   <= 8'd1;
                     r_state <= ST_SETTLE;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      bus.digits_o  = r_digits;
      bus.valid_o   = r_valid;
      bus.upd_o     = r_upd;
      bus.upd_idx_o = r_upd_idx;
      bus.err_o     = r_err;
      bus.err_idx_o = r_err_idx;
   end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reverse of the team's 4-bit-to-7-segment encoder: monitors a multiplexed, active-low 7-segment display bus (segment lines plus per-digit strobes) and recovers the 4-bit digit codes.
- Sits on the verification/loopback side of the clock display (hours/minutes/AM-PM digits). Lets the design self-check what is actually being driven to the HEX/scan outputs.
- Applies a stability filter per strobe window, holds the decoded code per digit, and flags undecodable patterns.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (2..255)
- TIMEOUT_CYCLES, 1024, cycles without a refresh before a digit's valid flag drops (used only with the optional feature)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- seg_i  in  7  segment lines, active-low, bit 6 = g … bit 0 = a
- dig_sel_i  in  NUM_DIGITS  digit strobes, active-low, one-hot-low when legal
- digits_o  out  4*NUM_DIGITS  decoded codes, digit k at [4k+3:4k]
- valid_o  out  NUM_DIGITS  digit k holds an accepted code
- upd_o  out  1  one-cycle pulse when any digit's stored code changes
- upd_idx_o  out  3  index of the digit that changed; meaningful when upd_o=1
- err_o  out  1  sticky: a stable but undecodable pattern was seen
- err_idx_o  out  3  digit index of the first error, frozen while err_o=1
- err_clr_i  in  1  clears err_o and err_idx_o (synchronous)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: digits_o=all 1s (code 4'hF, blank), valid_o=0, upd_o=0, upd_idx_o=0, err_o=0, err_idx_o=0, FSM=IDLE, counter=0.
- Inputs are registered once. All decisions use the registered copies, so there is 1 cycle of input latency.
- Decode table (pattern -> code), inverse of the encoder, all 16 patterns unique:
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0010000->9, 0001000->A, 0001100->B(P), 0111001->C, 0001111->D, 0111111->E(-), 1111111->F(blank)
  - Any other pattern is "unknown".
- Strobe legality:
  - Exactly one bit low -> legal, index = position of the low bit.
  - All high, or two or more low -> illegal; the FSM is forced to IDLE and the counter cleared.
- FSM states IDLE, SETTLE, HOLD:
  - IDLE: on a legal strobe, latch idx/pattern, cnt=1, go to SETTLE.
  - SETTLE: if idx and pattern are unchanged, cnt++. If either changes, re-latch, cnt=1, stay in SETTLE. When cnt reaches STABLE_CYCLES, accept and go to HOLD.
  - HOLD: stay while idx/pattern are unchanged. A change of either goes to SETTLE with cnt=1. An illegal strobe goes to IDLE.
- Accept action, applied on the cycle after cnt reaches STABLE_CYCLES (latency = 1 + STABLE_CYCLES cycles from the first stable input edge to the output update):
  - Decodable pattern: write digits_o[idx] and set valid_o[idx]=1. If the new code differs from the old one, or the digit was previously not valid, pulse upd_o with upd_idx_o=idx.
  - Unknown pattern: digits_o and valid_o are unchanged. If err_o=0, set err_o=1 and err_idx_o=idx.
- Exactly one accept per HOLD entry; no re-accept while in HOLD.
- err_clr_i and a new error in the same cycle: the new error wins (err_o stays 1, err_idx_o takes the new idx).
- An idx >= NUM_DIGITS cannot occur (the strobe is one-hot by width).
- rst asserted mid-SETTLE/HOLD: everything returns to reset values next cycle, with no upd_o pulse.

Optional Feature:
- Macro: SEG7_SCAN_DECODER_TIMEOUT_EN.
- Defined: per-digit refresh counter, reset on each accept for that digit. On reaching TIMEOUT_CYCLES, valid_o[k]=0 and digits_o[k]=4'hF, with no upd_o pulse. A later accept sets valid again and pulses upd_o.
- Undefined: valid_o bits stay set until rst; no counters are synthesized.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16 pattern constants SEG7_PAT_0..SEG7_PAT_F (active-low);
  - the code constants for blank/dash/A/P;
  - the FSM state typedef;
  - a decode function returning {known, code[3:0]}.
- The existing encoder is migrated to the same constants.
- One natural sub-module: seg7_pattern_decode, purely combinational, 7-bit pattern -> known + 4-bit code. It is reused by the bench scoreboard.

Test Plan:
- Digit 2 strobe (dig_sel_i=4'b1011) with seg_i=0100100 held 6 cycles -> after 1+4 cycles, digits_o[11:8]=2, valid_o=4'b0100, upd_o pulses once with upd_idx_o=2.
- Pattern toggles every 3 cycles, always shorter than STABLE_CYCLES=4 -> no update, valid_o stays 0, no upd_o.
- Scan 4 digits showing "12:59P"-style codes 1,2,5,9, each strobe held 8 cycles, two full scans -> first scan gives 4 upd_o pulses, second scan gives none. digits_o=16'h9521.
- Digit 0 stable on unknown pattern 1010101 -> err_o=1, err_idx_o=0, digits_o unchanged. Assert err_clr_i -> err_o=0 next cycle. Pulse err_clr_i in the same cycle as a new error on digit 3 -> err_o stays 1, err_idx_o=3.
- Two strobes low (4'b0011) with a stable pattern for 10 cycles -> FSM IDLE, no accept, no error.
- rst asserted during SETTLE -> all outputs return to reset values next cycle. With the timeout macro defined and TIMEOUT_CYCLES=16, a digit not refreshed for 16 cycles -> valid_o bit clears and its code reads F.
